// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the M:SS countdown timer: digit widths, BCD limits and the
// digit-level helpers used by the digit register bank.
package countdown_timer_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
   localparam int DEFAULT_TICKS_PER_SEC = 100;

   // Operating mode is implied by enable and zero; it is decoded, never stored.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_EXPIRED
   } timer_state_e;

   typedef struct packed {
      logic [BCD_W-1:0] min;
      logic [BCD_W-1:0] tens;
      logic [BCD_W-1:0] ones;
   } digits_t;

   function automatic logic is_zero(input digits_t d);
      return (d.min == '0) && (d.tens == '0) && (d.ones == '0);
   endfunction

   // One-second step with borrow; 0:00 is a floor, never wrapping to 9:59.
   function automatic digits_t bcd_decrement(input digits_t d);
      digits_t r;
      r = d;
      if (d.ones != '0) begin
         r.ones = d.ones - 4'd1;
      end else if (d.tens != '0) begin
         r.ones = DIGIT_MAX;
         r.tens = d.tens - 4'd1;
      end else if (d.min != '0) begin
         r.ones = DIGIT_MAX;
         r.tens = SEC_TENS_MAX;
         r.min  = d.min - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// One-second prescaler: tick fires on the last cycle of each full second while run is high.
// Dropping run discards the partial second so the next second always starts from scratch.
module tick_gen
   import countdown_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] count;

   assign tick = run && (count == LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!run || tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Keypad-loaded M:SS countdown timer: three BCD digit registers shifted in from the keypad,
// decremented once per second while enabled, with a zero flag and a one-cycle done pulse.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [BCD_W-1:0] data,
   input  logic             enable,
   output logic [BCD_W-1:0] min,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic             zero,
   output logic             done
);

   digits_t      digits;
   digits_t      digits_next;
   logic         done_next;
   timer_state_e state;
   logic         run;
   logic         tick;
   logic         load_ok;

   assign zero = is_zero(digits);

   always_comb begin
      state = ST_IDLE;
      if (zero) begin
         state = ST_EXPIRED;
      end else if (enable) begin
         state = ST_RUN;
      end
   end

   // clear also holds the prescaler in reset so a cleared timer restarts a full second.
   assign run = (state == ST_RUN) && !clear;

   tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_tick_gen (
      .clock(clock),
      .reset(reset),
      .run  (run),
      .tick (tick)
   );

   // A shifted-in digit lands in sec_tens next, so a current sec_ones above 5 blocks the entry.
   assign load_ok = load && !enable && (data <= DIGIT_MAX) && (digits.ones <= SEC_TENS_MAX);

   always_comb begin
      digits_next = digits;
      done_next   = 1'b0;
      if (clear) begin
         digits_next = '0;
      end else if (load_ok) begin
         digits_next.min  = digits.tens;
         digits_next.tens = digits.ones;
         digits_next.ones = data;
      end else if (tick) begin
         digits_next = bcd_decrement(digits);
         done_next   = is_zero(digits_next);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         digits <= '0;
         done   <= 1'b0;
      end else begin
         digits <= digits_next;
         done   <= done_next;
      end
   end

   assign min      = digits.min;
   assign sec_tens = digits.tens;
   assign sec_ones = digits.ones;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table for keypad entry, hand sequences for timing corners,
// then random traffic checked against a seconds-based reference model.
module tb_countdown_timer;

   localparam int TICKS = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       clear;
   logic       load;
   logic [3:0] data;
   logic       enable;
   logic [3:0] min;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       zero;
   logic       done;

   int checks = 0;
   int errors = 0;

   // Reference model: displayed digits plus elapsed cycles within the current second.
   int m_min;
   int m_tens;
   int m_ones;
   int m_phase;
   bit m_done;

   typedef struct {
      logic       clr;
      logic       ld;
      logic [3:0] dat;
      logic       en;
      int         em;
      int         et;
      int         eo;
      logic       ez;
      logic       ed;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   countdown_timer #(
      .TICKS_PER_SEC(TICKS)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .clear   (clear),
      .load    (load),
      .data    (data),
      .enable  (enable),
      .min     (min),
      .sec_tens(sec_tens),
      .sec_ones(sec_ones),
      .zero    (zero),
      .done    (done)
   );

   function automatic int model_secs();
      return m_min * 60 + m_tens * 10 + m_ones;
   endfunction

   task automatic model_reset();
      m_min   = 0;
      m_tens  = 0;
      m_ones  = 0;
      m_phase = 0;
      m_done  = 1'b0;
   endtask

   task automatic model_edge();
      int s;
      if (reset) begin
         model_reset();
         return;
      end
      if (clear) begin
         model_reset();
         return;
      end
      m_done = 1'b0;
      if (load && !enable && data <= 9 && m_ones <= 5) begin
         m_min  = m_tens;
         m_tens = m_ones;
         m_ones = int'(data);
      end
      s = model_secs();
      if (enable && s != 0) begin
         m_phase++;
         if (m_phase == TICKS) begin
            m_phase = 0;
            s--;
            m_min  = s / 60;
            m_tens = (s % 60) / 10;
            m_ones = s % 10;
            if (s == 0) m_done = 1'b1;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic apply_stimulus(input logic c, input logic l, input logic [3:0] d, input logic e);
      clear  = c;
      load   = l;
      data   = d;
      enable = e;
   endtask

   // One active edge: model follows the same inputs, outputs are sampled at the falling edge.
   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic check_val(input string name, input logic [3:0] got, input int expv);
      checks++;
      if (got !== 4'(expv)) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, expv, $time);
      end
   endtask

   task automatic check_output(input string name, input int em, input int et, input int eo,
                               input logic ez, input logic ed);
      check_val({name, " min"}, min, em);
      check_val({name, " sec_tens"}, sec_tens, et);
      check_val({name, " sec_ones"}, sec_ones, eo);
      check_val({name, " zero"}, {3'b0, zero}, int'(ez));
      check_val({name, " done"}, {3'b0, done}, int'(ed));
   endtask

   task automatic check_model(input string name);
      check_output(name, m_min, m_tens, m_ones, model_secs() == 0, m_done);
   endtask

   task automatic load_digit(input logic [3:0] d);
      apply_stimulus(1'b0, 1'b1, d, 1'b0);
      step();
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      logic en_r;
      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
      model_reset();
      repeat (2) @(negedge clock);
      check_output("reset", 0, 0, 0, 1'b1, 1'b0);
      reset = 1'b0;

      vecs.push_back('{1'b0, 1'b1, 4'd1, 1'b0, 0, 0, 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd3, 1'b0, 0, 1, 3, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 1, 3, 0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1, 3, 0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 0, 0, 0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 0, 0, 0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd9, 1'b0, 0, 0, 9, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd7, 1'b0, 0, 0, 9, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 0, 0, 0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'hC, 1'b0, 0, 0, 0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b0, 0, 0, 5, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 0, 0, 5, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd2, 1'b0, 0, 5, 2, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd8, 1'b0, 5, 2, 8, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 4'd3, 1'b0, 5, 2, 8, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 4'd3, 1'b0, 0, 0, 0, 1'b1, 1'b0});

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].clr, vecs[i].ld, vecs[i].dat, vecs[i].en);
         step();
         check_output($sformatf("vec%0d", i), vecs[i].em, vecs[i].et, vecs[i].eo,
                      vecs[i].ez, vecs[i].ed);
      end
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);

      // 1:00 rolls to 0:59 on the fourth edge after enable, then 0:58 four edges later.
      load_digit(4'd1);
      load_digit(4'd0);
      load_digit(4'd0);
      check_output("load 1:00", 1, 0, 0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1);
      repeat (3) step();
      check_output("1:00 before tick", 1, 0, 0, 1'b0, 1'b0);
      step();
      check_output("0:59", 0, 5, 9, 1'b0, 1'b0);
      repeat (4) step();
      check_output("0:58", 0, 5, 8, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0);
      step();
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);

      // 0:01 expiring: single done pulse, then silence while enable stays high at 0:00.
      load_digit(4'd0);
      load_digit(4'd1);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1);
      repeat (3) step();
      check_output("0:01 before tick", 0, 0, 1, 1'b0, 1'b0);
      step();
      check_output("expire", 0, 0, 0, 1'b1, 1'b1);
      step();
      check_output("done width", 0, 0, 0, 1'b1, 1'b0);
      repeat (6) step();
      check_output("hold at zero", 0, 0, 0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
      step();

      // Pause discards the partial second; clear during a run gives no done pulse.
      load_digit(4'd0);
      load_digit(4'd5);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1);
      repeat (6) step();
      check_output("0:04 mid second", 0, 0, 4, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
      repeat (3) step();
      check_output("paused", 0, 0, 4, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1);
      repeat (3) step();
      check_output("resume partial", 0, 0, 4, 1'b0, 1'b0);
      step();
      check_output("resume full", 0, 0, 3, 1'b0, 1'b0);
      repeat (2) step();
      apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1);
      step();
      check_output("clear in run", 0, 0, 0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1);
      step();
      check_output("after clear", 0, 0, 0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
      step();

      // Asynchronous reset mid-count and during a done pulse takes effect before the next edge.
      load_digit(4'd2);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1);
      repeat (6) step();
      check_output("pre reset", 0, 0, 1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1 check_output("async reset count", 0, 0, 0, 1'b1, 1'b0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);
      load_digit(4'd1);
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1);
      repeat (4) step();
      check_output("done before reset", 0, 0, 0, 1'b1, 1'b1);
      #2 reset = 1'b1;
      #1 check_output("async reset done", 0, 0, 0, 1'b1, 1'b0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0);

      // Random traffic; small digits are favoured so countdowns actually expire.
      en_r = 1'b0;
      for (int n = 0; n < 600; n++) begin
         logic       c;
         logic       l;
         logic [3:0] d;
         if ($urandom_range(0, 11) == 0) en_r = ~en_r;
         c = ($urandom_range(0, 39) == 0);
         l = ($urandom_range(0, 2) == 0);
         d = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
         apply_stimulus(c, l, d, en_r);
         step();
         check_model($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
